// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data-memory bus bundle for the load/store unit
interface lsu_if;
    logic        ip_req_valid;
    logic        op_req_ready;
    logic        ip_req_wr;
    logic [2:0]  ip_req_funct3;
    logic [31:0] ip_req_addr;
    logic [31:0] ip_req_wdata;
    logic        op_resp_valid;
    logic [31:0] op_resp_rdata;
    logic        op_resp_err;
    logic [31:0] op_data_addr;
    logic        op_data_wr;
    logic [3:0]  op_data_mask;
    logic [31:0] op_data_from_proc;
    logic        op_data_rd;
    logic        ip_data_valid;
    logic [31:0] ip_data_from_dmem;

    // Pipeline and memory side as seen by whoever drives the LSU
    modport master (
        output ip_req_valid, ip_req_wr, ip_req_funct3, ip_req_addr, ip_req_wdata,
        output ip_data_valid, ip_data_from_dmem,
        input  op_req_ready, op_resp_valid, op_resp_rdata, op_resp_err,
        input  op_data_addr, op_data_wr, op_data_mask, op_data_from_proc, op_data_rd
    );

    // The LSU itself
    modport slave (
        input  ip_req_valid, ip_req_wr, ip_req_funct3, ip_req_addr, ip_req_wdata,
        input  ip_data_valid, ip_data_from_dmem,
        output op_req_ready, op_resp_valid, op_resp_rdata, op_resp_err,
        output op_data_addr, op_data_wr, op_data_mask, op_data_from_proc, op_data_rd
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving a word-indexed data memory (optional LSU_TIMEOUT_EN access timeout)
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        wr_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  mask_q;

    logic        accept;
    logic        req_err;
    logic [3:0]  req_mask;
    logic [31:0] req_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        tmo_hit;

    assign accept = bus.ip_req_valid && (state == IDLE);

    // Alignment and legal-width check of the incoming request
    always_comb begin
        req_err = 1'b0;
        case (bus.ip_req_funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = bus.ip_req_addr[0];
            3'b010:         req_err = |bus.ip_req_addr[1:0];
            default:        req_err = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        req_mask = 4'b1111;
        req_data = bus.ip_req_wdata;
        case (bus.ip_req_funct3[1:0])
            2'b00: begin
                req_mask = 4'b0001 << bus.ip_req_addr[1:0];
                req_data = {4{bus.ip_req_wdata[7:0]}};
            end
            2'b01: begin
                req_mask = 4'b0011 << bus.ip_req_addr[1:0];
                req_data = {2{bus.ip_req_wdata[15:0]}};
            end
            default: begin
                req_mask = 4'b1111;
                req_data = bus.ip_req_wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned memory word
    always_comb begin
        ld_byte = bus.ip_data_from_dmem[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? bus.ip_data_from_dmem[31:16] : bus.ip_data_from_dmem[15:0];
        ld_ext  = 32'd0;
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = bus.ip_data_from_dmem;
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = 32'd0;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // Count ACCESS cycles, restarting on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A memory response on the last allowed cycle still completes normally
    assign tmo_hit = (state == ACCESS) && !bus.ip_data_valid &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; errors skip the memory access entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (bus.ip_data_valid || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch at accept and load-data capture at the end of ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            mask_q   <= 4'd0;
        end else if (accept) begin
            wr_q     <= bus.ip_req_wr;
            funct3_q <= bus.ip_req_funct3;
            lane_q   <= bus.ip_req_addr[1:0];
            err_q    <= req_err;
            if (req_err) begin
                rdata_q <= 32'd0;
            end else begin
                addr_q <= {2'b00, bus.ip_req_addr[31:2]};
                mask_q <= req_mask;
                data_q <= req_data;
            end
        end else if (state == ACCESS) begin
            if (bus.ip_data_valid) begin
                rdata_q <= wr_q ? 32'd0 : ld_ext;
            end else if (tmo_hit) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.op_req_ready      = (state == IDLE);
    assign bus.op_resp_valid     = (state == RESP);
    assign bus.op_resp_err       = (state == RESP) && err_q;
    assign bus.op_resp_rdata     = rdata_q;
    assign bus.op_data_rd        = (state == ACCESS) && !wr_q;
    assign bus.op_data_wr        = (state == ACCESS) && wr_q;
    assign bus.op_data_addr      = addr_q;
    assign bus.op_data_mask      = mask_q;
    assign bus.op_data_from_proc = data_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against a byte-addressed reference model
module tb_lsu;

    localparam int TMO = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    lsu_if lsu_bus ();

    lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lsu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference memory: plain bytes. Bench memory: words seen by the DUT.
    logic [7:0]  ref_mem [0:255];
    logic [31:0] dmem    [0:63];

    int          wait_cyc;
    int          busy;
    logic        hang;
    logic        noise;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] seen_addr;
    logic [3:0]  seen_mask;
    logic [31:0] seen_data;

    // Memory responder with programmable wait states and idle-time valid noise
    always @(negedge clk) begin
        if (lsu_bus.op_data_rd || lsu_bus.op_data_wr) begin
            if (lsu_bus.op_data_rd) rd_cnt++;
            if (lsu_bus.op_data_wr) wr_cnt++;
            seen_addr = lsu_bus.op_data_addr;
            seen_mask = lsu_bus.op_data_mask;
            seen_data = lsu_bus.op_data_from_proc;
            if (!hang && busy == wait_cyc) begin
                lsu_bus.ip_data_valid     = 1'b1;
                lsu_bus.ip_data_from_dmem = dmem[lsu_bus.op_data_addr[5:0]];
                if (lsu_bus.op_data_wr) begin
                    for (int j = 0; j < 4; j++)
                        if (lsu_bus.op_data_mask[j])
                            dmem[lsu_bus.op_data_addr[5:0]][8*j +: 8] = lsu_bus.op_data_from_proc[8*j +: 8];
                end
                busy = 0;
            end else begin
                lsu_bus.ip_data_valid     = 1'b0;
                lsu_bus.ip_data_from_dmem = $urandom;
                busy++;
            end
        end else begin
            busy = 0;
            lsu_bus.ip_data_valid     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            lsu_bus.ip_data_from_dmem = $urandom;
        end
    end

    function automatic int width_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic [2:0] f3, input logic [31:0] addr);
        int a = int'(addr[7:0]);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (a % width_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int     a = int'(addr[7:0]);
        int     n = width_bytes(f3);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] m = 4'd0;
        for (int i = 0; i < width_bytes(f3); i++) m[int'(addr[1:0]) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % width_bytes(f3)) +: 8];
        return d;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < width_bytes(f3); i++) ref_mem[int'(addr[7:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        dmem[idx] = val;
        for (int j = 0; j < 4; j++) ref_mem[idx*4 + j] = val[8*j +: 8];
    endtask

    // Drive one request; returns response fields, latency in cycles from accept,
    // whether ready stayed low until the response, and the accept cycle
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic got, output logic [31:0] rdata,
                         output logic err, output int lat, output logic rdy_low, output int acc);
        int k = 0;
        got = 1'b0; rdata = 'x; err = 'x; lat = 0; rdy_low = 1'b1; acc = 0;
        rd_cnt = 0; wr_cnt = 0;
        lsu_bus.ip_req_valid  = 1'b1;
        lsu_bus.ip_req_wr     = wr;
        lsu_bus.ip_req_funct3 = f3;
        lsu_bus.ip_req_addr   = addr;
        lsu_bus.ip_req_wdata  = wd;
        while (!lsu_bus.op_req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!lsu_bus.op_req_ready) begin
            lsu_bus.ip_req_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        lsu_bus.ip_req_valid  = 1'b0;
        lsu_bus.ip_req_wr     = 1'($urandom_range(0, 1));
        lsu_bus.ip_req_funct3 = 3'($urandom_range(0, 7));
        lsu_bus.ip_req_addr   = $urandom;
        lsu_bus.ip_req_wdata  = $urandom;
        lat = 1;
        for (int t = 0; t < 40; t++) begin
            if (lsu_bus.op_req_ready) rdy_low = 1'b0;
            if (lsu_bus.op_resp_valid) begin
                got   = 1'b1;
                rdata = lsu_bus.op_resp_rdata;
                err   = lsu_bus.op_resp_err;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    logic        got, err, rdy_low;
    logic [31:0] rdata;
    int          lat, acc;

    task automatic test_reset();
        n_cmp++; if (lsu_bus.op_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", lsu_bus.op_req_ready); end
        n_cmp++; if (lsu_bus.op_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", lsu_bus.op_resp_valid); end
        n_cmp++; if (lsu_bus.op_resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", lsu_bus.op_resp_err); end
        n_cmp++; if ({lsu_bus.op_data_rd, lsu_bus.op_data_wr} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b%b want 00", lsu_bus.op_data_rd, lsu_bus.op_data_wr); end
        n_cmp++; if (lsu_bus.op_resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", lsu_bus.op_resp_rdata); end
        n_cmp++; if (lsu_bus.op_data_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", lsu_bus.op_data_addr); end
        n_cmp++; if (lsu_bus.op_data_mask !== 4'd0) begin n_bad++; $display("FAIL reset_mask: got %b want 0", lsu_bus.op_data_mask); end
        n_cmp++; if (lsu_bus.op_data_from_proc !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", lsu_bus.op_data_from_proc); end
    endtask

    task automatic test_store_load();
        wait_cyc = 0;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, rdata, err, lat, rdy_low, acc);
        ref_store(3'b010, 32'h10, 32'hDEADBEEF);
        n_cmp++; if (seen_addr !== 32'd4) begin n_bad++; $display("FAIL sw_addr: got %h want 4", seen_addr); end
        n_cmp++; if (seen_mask !== 4'b1111) begin n_bad++; $display("FAIL sw_mask: got %b want 1111", seen_mask); end
        n_cmp++; if (seen_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_data: got %h want deadbeef", seen_data); end
        n_cmp++; if (wr_cnt !== 1 || rd_cnt !== 0) begin n_bad++; $display("FAIL sw_strobes: got wr=%0d rd=%0d want wr=1 rd=0", wr_cnt, rd_cnt); end
        n_cmp++; if (got !== 1'b1 || lat !== 2 || err !== 1'b0) begin n_bad++; $display("FAIL sw_resp: got got=%b lat=%0d err=%b want 1/2/0", got, lat, err); end

        issue(1'b1, 3'b000, 32'h13, 32'h000000A5, got, rdata, err, lat, rdy_low, acc);
        ref_store(3'b000, 32'h13, 32'h000000A5);
        n_cmp++; if (seen_mask !== 4'b1000) begin n_bad++; $display("FAIL sb_mask: got %b want 1000", seen_mask); end
        n_cmp++; if (seen_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_data: got %h want a5a5a5a5", seen_data); end
        issue(1'b0, 3'b000, 32'h13, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rdata !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffffa5", rdata); end
        issue(1'b0, 3'b100, 32'h13, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rdata !== 32'h000000A5) begin n_bad++; $display("FAIL lbu_rdata: got %h want 000000a5", rdata); end

        set_word(4, 32'h80011234);
        issue(1'b0, 3'b001, 32'h12, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rdata !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff8001", rdata); end
        issue(1'b0, 3'b101, 32'h12, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rdata !== 32'h00008001) begin n_bad++; $display("FAIL lhu_rdata: got %h want 00008001", rdata); end
    endtask

    task automatic test_errors();
        logic [31:0] ea [3];
        logic [2:0]  ef [3];
        logic        ew [3];
        ea[0] = 32'h06; ef[0] = 3'b010; ew[0] = 1'b0;
        ea[1] = 32'h01; ef[1] = 3'b001; ew[1] = 1'b1;
        ea[2] = 32'h00; ef[2] = 3'b011; ew[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(ew[i], ef[i], ea[i], 32'h12345678, got, rdata, err, lat, rdy_low, acc);
            n_cmp++; if (got !== 1'b1 || err !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL err_resp[%0d]: got got=%b err=%b lat=%0d want 1/1/1", i, got, err, lat); end
            n_cmp++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_bad++; $display("FAIL err_strobes[%0d]: got rd=%0d wr=%0d want 0/0", i, rd_cnt, wr_cnt); end
            n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL err_rdata[%0d]: got %h want 0", i, rdata); end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp;
        wait_cyc = 3;
        exp = ref_load(3'b010, 32'h20);
        issue(1'b0, 3'b010, 32'h20, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rd_cnt !== 4) begin n_bad++; $display("FAIL wait_rd_cycles: got %0d want 4", rd_cnt); end
        n_cmp++; if (rdy_low !== 1'b1) begin n_bad++; $display("FAIL wait_ready_low: got %b want 1", rdy_low); end
        n_cmp++; if (got !== 1'b1 || lat !== 5 || err !== 1'b0 || rdata !== exp) begin n_bad++; $display("FAIL wait_resp: got lat=%0d err=%b rdata=%h want 5/0/%h", lat, err, rdata, exp); end
        @(negedge clk);
        n_cmp++; if (lsu_bus.op_resp_valid !== 1'b0 || lsu_bus.op_req_ready !== 1'b1) begin n_bad++; $display("FAIL wait_single_pulse: got valid=%b ready=%b want 0/1", lsu_bus.op_resp_valid, lsu_bus.op_req_ready); end
        wait_cyc = 0;
    endtask

    task automatic test_back_to_back();
        int prev;
        wait_cyc = 0;
        issue(1'b0, 3'b010, 32'h40, 32'h0, got, rdata, err, lat, rdy_low, acc);
        prev = acc;
        for (int i = 0; i < 4; i++) begin
            issue(i[0], 3'b010, 32'(32'h40 + 4*i), 32'(i), got, rdata, err, lat, rdy_low, acc);
            if (i[0]) ref_store(3'b010, 32'(32'h40 + 4*i), 32'(i));
            n_cmp++; if (acc - prev !== 3) begin n_bad++; $display("FAIL b2b_period[%0d]: got %0d want 3", i, acc - prev); end
            prev = acc;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        wr, eerr;
        logic [2:0]  f3;
        logic [31:0] a, wd, erd;
        noise = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            wait_cyc = $urandom_range(0, 2);
            eerr = ref_err(f3, a);
            erd  = (wr || eerr) ? 32'd0 : ref_load(f3, a);
            issue(wr, f3, a, wd, got, rdata, err, lat, rdy_low, acc);
            if (wr && !eerr) ref_store(f3, a, wd);
            n_cmp++; if (got !== 1'b1 || err !== eerr || rdata !== erd) begin n_bad++; $display("FAIL rnd_resp[%0d]: got got=%b err=%b rdata=%h want 1/%b/%h", i, got, err, rdata, eerr, erd); end
            n_cmp++; if (lat !== (eerr ? 1 : 2 + wait_cyc) || rdy_low !== 1'b1) begin n_bad++; $display("FAIL rnd_latency[%0d]: got lat=%0d rdy_low=%b want %0d/1", i, lat, rdy_low, eerr ? 1 : 2 + wait_cyc); end
            n_cmp++; if (rd_cnt !== ((!wr && !eerr) ? wait_cyc + 1 : 0) || wr_cnt !== ((wr && !eerr) ? wait_cyc + 1 : 0)) begin n_bad++; $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d", i, rd_cnt, wr_cnt); end
            if (!eerr) begin
                n_cmp++; if (seen_addr !== {2'b00, a[31:2]} || seen_mask !== ref_mask(f3, a)) begin n_bad++; $display("FAIL rnd_addr_mask[%0d]: got %h/%b want %h/%b", i, seen_addr, seen_mask, {2'b00, a[31:2]}, ref_mask(f3, a)); end
                if (wr) begin
                    n_cmp++; if (seen_data !== ref_lanes(f3, wd)) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, seen_data, ref_lanes(f3, wd)); end
                end
            end
        end
        noise = 1'b0;
        wait_cyc = 0;
        @(negedge clk);
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        hang = 1'b1;
        issue(1'b0, 3'b010, 32'h24, 32'h0, got, rdata, err, lat, rdy_low, acc);
        n_cmp++; if (rd_cnt !== TMO) begin n_bad++; $display("FAIL tmo_rd_cycles: got %0d want %0d", rd_cnt, TMO); end
        n_cmp++; if (got !== 1'b1 || err !== 1'b1 || rdata !== 32'd0 || lat !== TMO + 1) begin n_bad++; $display("FAIL tmo_resp: got got=%b err=%b rdata=%h lat=%0d want 1/1/0/%0d", got, err, rdata, lat, TMO + 1); end
        hang = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_abort();
        int resp_seen = 0;
        hang = 1'b1;
        lsu_bus.ip_req_valid  = 1'b1;
        lsu_bus.ip_req_wr     = 1'b0;
        lsu_bus.ip_req_funct3 = 3'b010;
        lsu_bus.ip_req_addr   = 32'h28;
        @(negedge clk);
        lsu_bus.ip_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (lsu_bus.op_data_rd !== 1'b1) begin n_bad++; $display("FAIL abort_in_access: got rd=%b want 1", lsu_bus.op_data_rd); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (lsu_bus.op_req_ready !== 1'b1 || lsu_bus.op_data_rd !== 1'b0 || lsu_bus.op_resp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_ctrl: got ready=%b rd=%b valid=%b want 1/0/0", lsu_bus.op_req_ready, lsu_bus.op_data_rd, lsu_bus.op_resp_valid); end
        n_cmp++; if (lsu_bus.op_data_addr !== 32'd0 || lsu_bus.op_data_mask !== 4'd0 || lsu_bus.op_data_from_proc !== 32'd0 || lsu_bus.op_resp_rdata !== 32'd0) begin n_bad++; $display("FAIL abort_data: got addr=%h mask=%b data=%h rdata=%h want zeros", lsu_bus.op_data_addr, lsu_bus.op_data_mask, lsu_bus.op_data_from_proc, lsu_bus.op_resp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        hang  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lsu_bus.op_resp_valid) resp_seen++;
            @(negedge clk);
        end
        n_cmp++; if (resp_seen !== 0) begin n_bad++; $display("FAIL abort_no_resp: got %0d pulses want 0", resp_seen); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        wait_cyc = 0; busy = 0; hang = 1'b0; noise = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        seen_addr = '0; seen_mask = '0; seen_data = '0;
        lsu_bus.ip_req_valid  = 1'b0;
        lsu_bus.ip_req_wr     = 1'b0;
        lsu_bus.ip_req_funct3 = 3'b000;
        lsu_bus.ip_req_addr   = 32'd0;
        lsu_bus.ip_req_wdata  = 32'd0;
        lsu_bus.ip_data_valid = 1'b0;
        lsu_bus.ip_data_from_dmem = 32'd0;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_errors();
        test_wait_states();
        test_back_to_back();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
